case_stream_ctrl: RTL

Two-requester byte-stream scheduler wrapped around the ASCII case-conversion datapath. It arbitrates round-robin between channels A and B, applies each channel's conversion mode (pass, to-upper, to-lower, toggle) and delivers the byte through a one-entry registered output stage with a valid/ready handshake. It also tags each output byte with its source channel and counts bytes whose value was actually changed. It sits between character producers (UART RX, test pattern sources) and the single downstream text sink.

---
 rtl/case_stream_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/case_stream_ctrl.sv
// case_stream_ctrl: two-channel round-robin byte scheduler feeding the ASCII
// case-conversion datapath. Each channel carries its own conversion mode. The
// converted byte goes into a one-entry registered output stage with valid/ready,
// is tagged with its source channel, and bytes whose value changed are counted.
module case_stream_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [7:0]       a_data,
    input  logic [1:0]       a_mode,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [7:0]       b_data,
    input  logic [1:0]       b_mode,
    output logic             b_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_src,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] mod_count
);

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam logic [1:0] MODE_UPPER  = 2'b01;
    localparam logic [1:0] MODE_LOWER  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    logic       last_grant;
    logic       take;
    logic       grant_a;
    logic       grant_b;
    logic       accept;
    logic [7:0] sel_data;
    logic [1:0] sel_mode;
    logic [7:0] conv_data;
    logic       changed;

    // Case conversion: only ASCII letters are ever touched, and only bit 5 moves.
    function automatic logic [7:0] convert(input logic [7:0] d, input logic [1:0] m);
        logic is_lower;
        logic is_upper;
        logic [7:0] r;
        is_lower = (d >= 8'h61) && (d <= 8'h7A);
        is_upper = (d >= 8'h41) && (d <= 8'h5A);
        r = d;
        case (m)
            MODE_UPPER:  if (is_lower) r = d & 8'hDF;
            MODE_LOWER:  if (is_upper) r = d | 8'h20;
            MODE_TOGGLE: if (is_lower || is_upper) r = d ^ 8'h20;
            default:     r = d;
        endcase
        return r;
    endfunction

    // Arbitration and handshake: readies depend only on valids, out_ready,
    // the output stage state and last_grant, never on data or mode.
    always_comb begin
        take    = !out_valid || out_ready;
        grant_a = a_valid && (!b_valid || (last_grant == SRC_B));
        grant_b = b_valid && (!a_valid || (last_grant == SRC_A));
        a_ready = !rst && take && grant_a;
        b_ready = !rst && take && grant_b;
        accept  = a_ready || b_ready;
    end

    // Datapath: select the granted channel's byte and mode, then convert.
    always_comb begin
        sel_data  = b_ready ? b_data : a_data;
        sel_mode  = b_ready ? b_mode : a_mode;
        conv_data = convert(sel_data, sel_mode);
        changed   = (conv_data != sel_data);
    end

    // One-entry output register: load on accept, empty when drained with no refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_src   <= SRC_A;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= conv_data;
            out_src   <= b_ready ? SRC_B : SRC_A;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin memory: remembers the last channel that actually transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_B;
        end else if (accept) begin
            last_grant <= b_ready ? SRC_B : SRC_A;
        end
    end

    // Modified-byte counter: clear beats increment, wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            mod_count <= '0;
        end else if (accept && changed) begin
            mod_count <= mod_count + 1'b1;
        end
    end

endmodule
